// File: rtl/key_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_evt_pkg
// Summary  : Shared constants and event-entry layout for the key event front
//            end (debounce defaults, FIFO depth, packed event field helpers).
// Revision : 1.0 - initial release
// ============================================================================
package key_evt_pkg;

    // Default configuration of the key front end.
    localparam int unsigned DEFAULT_NUM_KEYS        = 4;
    localparam int unsigned DEFAULT_KEY_W           = 2;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
    localparam int unsigned DEFAULT_CNT_W           = 19;
    localparam int unsigned DEFAULT_FIFO_DEPTH      = 4;

    // An event entry carries the key index in its LSBs and the press bit
    // directly above it, so one entry is KEY_W+1 bits wide.
    function automatic int unsigned evt_width(input int unsigned key_w);
        return key_w + 1;
    endfunction

    function automatic int unsigned evt_press_bit(input int unsigned key_w);
        return key_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Summary  : Single-key conditioning: 2-flop synchronizer, persistence counter
//            and accepted (stable) level. 'change' pulses for one cycle in the
//            cycle after 'stable' takes a new value.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
    import key_evt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,     // synchronous, active-low
    input  logic key_raw,
    output logic stable,
    output logic change
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic             r_change;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchronizer for the asynchronous switch level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= key_raw;
            r_s2 <= r_s1;
        end
    end

    // Accept a new level only after it has differed from the stable level
    // for DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_change <= 1'b0;
        end else begin
            r_change <= 1'b0;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
                r_change <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stable = r_stable;
    assign change = r_change;

endmodule
`default_nettype wire

// File: rtl/key_event_sync.sv
`default_nettype none
// ============================================================================
// Module   : key_event_sync
// Summary  : Key switch front end. Per-key synchronize + debounce, edge
//            capture into pending flags, fixed-priority arbiter (lowest index
//            first) and a small event FIFO with a valid/ready pop interface.
// Config   : KEY_EVT_RELEASE_EN - when defined, release events are queued as
//            well as presses; otherwise only presses are queued and evt_press
//            is tied high.
// Revision : 1.0 - initial release
// ============================================================================
module key_event_sync
    import key_evt_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = DEFAULT_NUM_KEYS,
    parameter int unsigned KEY_W           = DEFAULT_KEY_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W,
    parameter int unsigned FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
    input  logic                clock,
    input  logic                reset,        // synchronous, active-low
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] keys_stable,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_W-1:0]    evt_key,
    output logic                evt_press,
    output logic                overflow
);

    localparam int unsigned c_EVT_W     = evt_width(KEY_W);
    localparam int unsigned c_PRESS_BIT = evt_press_bit(KEY_W);
    localparam int unsigned c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

`ifdef KEY_EVT_RELEASE_EN
    localparam logic c_RELEASE_EN = 1'b1;
`else
    localparam logic c_RELEASE_EN = 1'b0;
`endif

    // Per-key conditioning outputs
    logic [NUM_KEYS-1:0] w_stable;
    logic [NUM_KEYS-1:0] w_change;
    logic [NUM_KEYS-1:0] w_set;

    // Pending event flags and their captured direction
    logic [NUM_KEYS-1:0] r_pend;
    logic [NUM_KEYS-1:0] r_dir;

    // Arbiter
    logic                w_any_pend;
    logic [KEY_W-1:0]    w_grant_idx;
    logic [NUM_KEYS-1:0] w_grant;

    // Event FIFO
    logic [c_EVT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [c_EVT_W-1:0]  w_wr_data;
    logic [c_EVT_W-1:0]  w_head;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clock   (clock),
            .reset   (reset),
            .key_raw (keys_raw[k]),
            .stable  (w_stable[k]),
            .change  (w_change[k])
        );
    end

    // A stable change becomes a pending event; releases only when enabled.
    always_comb begin
        w_set = w_change & (w_stable | {NUM_KEYS{c_RELEASE_EN}});
    end

    // Lowest-index pending key wins; scanning downward lets the lowest overwrite.
    always_comb begin
        w_any_pend  = 1'b0;
        w_grant_idx = '0;
        w_grant     = '0;
        for (int k = int'(NUM_KEYS) - 1; k >= 0; k--) begin
            if (r_pend[k]) begin
                w_any_pend  = 1'b1;
                w_grant_idx = KEY_W'(k);
                w_grant     = '0;
                w_grant[k]  = 1'b1;
            end
        end
    end

    // Served flag clears even when the write is dropped; a new change in the
    // same cycle re-arms the flag and its direction (later level wins).
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pend <= '0;
            r_dir  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | w_set;
            r_dir  <= (r_dir & ~w_set) | (w_stable & w_set);
        end
    end

    // FIFO control: a pop frees the slot the same-cycle write needs when full.
    always_comb begin
        w_full    = (r_count == c_FULL);
        w_pop     = (r_count != '0) && evt_ready;
        w_push    = w_any_pend && (!w_full || w_pop);
        w_drop    = w_any_pend && w_full && !w_pop;
        w_wr_data = {r_dir[w_grant_idx], w_grant_idx};
        w_head    = r_mem[r_rd_ptr];
    end

    // Event storage; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign keys_stable = w_stable;
    assign evt_valid   = (r_count != '0);
    assign evt_key     = w_head[KEY_W-1:0];
    assign evt_press   = w_head[c_PRESS_BIT] | ~c_RELEASE_EN;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_event_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_event_sync
// Summary  : Self-checking bench for key_event_sync with a short debounce
//            window. Directed scenarios plus random key activity, all checked
//            against a behavioural event model (queue-based FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_sync;

    localparam int NK    = 4;
    localparam int KW    = 2;
    localparam int DEB   = 8;
    localparam int CW    = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = DEB + 3;   // edge index (from 0) after which evt_valid is high

`ifdef KEY_EVT_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic          clock     = 1'b0;
    logic          reset     = 1'b0;
    logic [NK-1:0] keys_raw  = '0;
    logic          evt_ready = 1'b0;
    logic [NK-1:0] keys_stable;
    logic          evt_valid;
    logic [KW-1:0] evt_key;
    logic          evt_press;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    key_event_sync #(
        .NUM_KEYS        (NK),
        .KEY_W           (KW),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW),
        .FIFO_DEPTH      (DEPTH)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .keys_raw    (keys_raw),
        .keys_stable (keys_stable),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_key     (evt_key),
        .evt_press   (evt_press),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [KW-1:0] key;
        logic          press;
    } evt_t;

    logic [NK-1:0] m_s1, m_s2, m_stable, m_chg, m_pend, m_dir;
    int            m_run [NK];
    logic          m_ovf;
    evt_t          m_q [$];
    int            popped [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs seen at the edge.
    task automatic model_step();
        int   g;
        logic pop;
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_chg = '0;
            m_pend = '0; m_dir = '0; m_ovf = 1'b0;
            m_q.delete();
            foreach (m_run[k]) m_run[k] = 0;
            return;
        end
        pop = (m_q.size() != 0) && evt_ready;
        g = -1;
        for (int k = NK - 1; k >= 0; k--) if (m_pend[k]) g = k;
        if (pop) void'(m_q.pop_front());
        if (g >= 0) begin
            if (m_q.size() < DEPTH) m_q.push_back('{key: KW'(g), press: m_dir[g]});
            else m_ovf = 1'b1;
            m_pend[g] = 1'b0;
        end
        for (int k = 0; k < NK; k++) begin
            if (m_chg[k] && (REL || m_stable[k])) begin
                m_pend[k] = 1'b1;
                m_dir[k]  = m_stable[k];
            end
        end
        // a level is accepted on its DEB-th consecutive differing sample
        for (int k = 0; k < NK; k++) begin
            m_chg[k] = 1'b0;
            if (m_s2[k] == m_stable[k]) begin
                m_run[k] = 0;
            end else begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_stable[k] = m_s2[k];
                    m_run[k]    = 0;
                    m_chg[k]    = 1'b1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = keys_raw;
    endtask

    task automatic compare_all();
        check_eq("keys_stable", keys_stable, m_stable);
        check_eq("evt_valid", evt_valid, m_q.size() != 0);
        check_eq("overflow", overflow, m_ovf);
        if (m_q.size() != 0) begin
            check_eq("evt_key", evt_key, m_q[0].key);
            check_eq("evt_press", evt_press, m_q[0].press);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic step(input int k, input logic lvl);
        keys_raw[k] = lvl;
        run(DEB + 6);
    endtask

    task automatic wait_valid(output int edge_idx);
        edge_idx = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (evt_valid) begin
                edge_idx = n;
                break;
            end
        end
    endtask

    task automatic drain();
        popped.delete();
        evt_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (evt_valid) popped.push_back(int'(evt_key));
            tick();
            if (!evt_valid) break;
        end
        evt_ready = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        run(n);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen;
        int k0, n0, k1, n1;
        int found;
        int exp_drain [4];
        int k5;

        // ---- reset state ----
        run(3);
        check_eq("rst_valid", evt_valid, 0);
        check_eq("rst_key", evt_key, 0);
        check_eq("rst_press", evt_press, REL ? 0 : 1);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_stable", keys_stable, 0);
        reset = 1'b1;
        run(2);

        // ---- isolated press of key 2: latency and head contents ----
        keys_raw = 4'b0100;
        wait_valid(lat);
        check_eq("press_lat", lat, LAT);
        check_eq("press_key", evt_key, 2);
        check_eq("press_dir", evt_press, 1);
        check_eq("press_stable", keys_stable, 4'b0100);
        evt_ready = 1'b1;
        tick();
        check_eq("pop_valid", evt_valid, 0);
        keys_raw = '0;
        run(DEB + 8);

        // ---- glitch shorter than the debounce window ----
        seen = 0;
        keys_raw[0] = 1'b1;
        for (int n = 0; n < 25; n++) begin
            if (n == 5) keys_raw[0] = 1'b0;
            tick();
            if (evt_valid) seen++;
        end
        check_eq("glitch_events", seen, 0);
        check_eq("glitch_stable", keys_stable, 0);

        // ---- simultaneous keys 1 and 3: priority order, back to back ----
        keys_raw = 4'b1010;
        k0 = -1; k1 = -1; n0 = -1; n1 = -1;
        for (int n = 0; n < 40; n++) begin
            if (evt_valid) begin
                if (k0 < 0) begin k0 = int'(evt_key); n0 = n; end
                else if (k1 < 0) begin k1 = int'(evt_key); n1 = n; end
            end
            tick();
            if (k1 >= 0) break;
        end
        check_eq("simul_first", k0, 1);
        check_eq("simul_second", k1, 3);
        check_eq("simul_gap", n1 - n0, 1);
        keys_raw = '0;
        run(DEB + 8);
        evt_ready = 1'b0;

        // ---- six edges while stalled: four kept, two dropped ----
`ifdef KEY_EVT_RELEASE_EN
        step(0, 1); step(1, 1); step(2, 1); step(0, 0); step(1, 0); step(2, 0);
        exp_drain = '{0, 1, 2, 0};
`else
        step(0, 1); step(1, 1); step(2, 1); step(3, 1);
        keys_raw = '0; run(DEB + 6);
        step(0, 1); step(1, 1);
        exp_drain = '{0, 1, 2, 3};
`endif
        check_eq("stall_ovf", overflow, 1);
        check_eq("stall_head", evt_key, 0);
        drain();
        check_eq("drain_count", popped.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq("drain_key", (i < popped.size()) ? popped[i] : -1, exp_drain[i]);
        check_eq("ovf_sticky", overflow, 1);

        // ---- full FIFO, write coincides with a pop ----
        keys_raw = '0;
        do_reset(2);
        run(2);
`ifdef KEY_EVT_RELEASE_EN
        step(0, 1); step(1, 1); step(0, 0); step(1, 0);
        keys_raw[2] = 1'b1;
        k5 = 2;
`else
        step(0, 1); step(1, 1); step(2, 1); step(3, 1);
        keys_raw = '0; run(DEB + 6);
        keys_raw[0] = 1'b1;
        k5 = 0;
`endif
        check_eq("full_valid", evt_valid, 1);
        found = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (m_pend != '0) begin
                found = 1;
                break;
            end
        end
        check_eq("coincide_seen", found, 1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_eq("coincide_ovf", overflow, 0);
        drain();
        check_eq("coincide_count", popped.size(), 4);
        check_eq("coincide_last", (popped.size() == 4) ? popped[3] : -1, k5);

        // ---- reset with three queued events and key 0 held ----
`ifdef KEY_EVT_RELEASE_EN
        step(0, 1); step(1, 1); step(1, 0);
`else
        step(0, 0); step(1, 1); step(2, 1); step(0, 1);
`endif
        check_eq("queued_valid", evt_valid, 1);
        reset = 1'b0;
        tick();
        check_eq("rst2_valid", evt_valid, 0);
        check_eq("rst2_ovf", overflow, 0);
        reset = 1'b1;
        wait_valid(lat);
        check_eq("rst2_lat", lat, LAT);
        check_eq("rst2_key", evt_key, 0);
        check_eq("rst2_press", evt_press, 1);

        // ---- random key activity and consumer back-pressure ----
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 1200; n++) begin
                evt_ready = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    int k;
                    k = $urandom_range(0, NK - 1);
                    keys_raw[k] = ~keys_raw[k];
                end
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event_sync.md
Name: key_event_sync

Overview:
- Upstream front end for the synthesizer GUI. Conditions the raw key switches: 2-flop synchronizer, per-key debounce, then edge detection.
- Emits discrete press/release events through a small FIFO using a valid/ready handshake.
- The GUI draw controller pops one event per redraw. It keeps keys_stable as the level view.

Parameters:
- NUM_KEYS, 4, number of key inputs (2..8).
- KEY_W, 2, event key-index width. Must equal clog2(NUM_KEYS).
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized level must persist before acceptance (10 ms at 50 MHz). Must be at least 2.
- CNT_W, 19, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- FIFO_DEPTH, 4, event FIFO entries (power of 2).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low.
- keys_raw  in  NUM_KEYS  asynchronous switch levels; 1 = pressed.
- keys_stable  out  NUM_KEYS  debounced levels.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_key  out  KEY_W  key index of the head event.
- evt_press  out  1  1 = press, 0 = release.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset = 0 at a clock edge) clears:
  - synchronizers and counters;
  - keys_stable = 0 and all pending flags;
  - FIFO empty, so evt_valid = 0, evt_key = 0, evt_press = 0;
  - overflow = 0.
  - Reset mid-operation discards queued and in-flight events. keys held at reset re-emit press events after debounce.
- Synchronizer: s1 <= keys_raw, s2 <= s1, per bit.
- Debounce, per key:
  - If s2 == stable, cnt <= 0.
  - Otherwise cnt increments. When cnt == DEBOUNCE_CYCLES-1 and s2 still differs, stable <= s2 and cnt <= 0.
  - A mismatch shorter than DEBOUNCE_CYCLES cycles leaves stable unchanged.
- Edge capture: a stable change at edge E sets pending[k] and pend_dir[k] = new level at edge E+1.
  - A second change of the same key before its pending flag is served overwrites pend_dir. The later level wins.
- Arbiter: each cycle, the lowest-index pending key is written to the FIFO as {k, pend_dir[k]} and its pending flag clears. At most one write per cycle.
  - Higher-index keys wait. Fixed priority is acceptable because debounce windows are far longer than NUM_KEYS cycles.
- FIFO full:
  - A write attempted while full and without a same-cycle pop is dropped. The pending flag still clears and overflow <= 1.
  - overflow is cleared only by reset.
  - A write and a pop in the same cycle while full both succeed; count is unchanged.
- Handshake:
  - Pop when evt_valid && evt_ready.
  - evt_key and evt_press are held stable while evt_valid && !evt_ready.
  - evt_ready while empty has no effect.
  - Outputs are driven from registered head storage; there is no combinational path from evt_ready to evt_valid.
- Latency, isolated edge with empty FIFO: keys_raw changes before edge 0 →
  - s2 at edge 1;
  - stable at edge 1+DEBOUNCE_CYCLES;
  - pending at edge 2+DEBOUNCE_CYCLES;
  - evt_valid high after edge 3+DEBOUNCE_CYCLES.
- Pointers wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1.

Optional Feature:
- Macro: KEY_EVT_RELEASE_EN.
- Defined: release events (evt_press = 0) are queued as described above.
- Undefined: only 0→1 stable transitions set pending. evt_press is constant 1. keys_stable still tracks releases.

Decomposition:
- Package key_evt_pkg holds:
  - event field layout: key index LSBs, press bit MSB, entry width KEY_W+1;
  - default DEBOUNCE_CYCLES;
  - FIFO depth constant.
- Sub-module key_debounce covers one key: synchronizer, counter and stable register, exposing stable and a change pulse. It is instantiated NUM_KEYS times via generate.
- Arbiter and FIFO stay in the top module.

Test Plan (DEBOUNCE_CYCLES = 8 for simulation):
- Press key 2 and hold → evt_valid rises exactly 11 edges later with evt_key = 2, evt_press = 1. keys_stable = 4'b0100. With evt_ready = 1, evt_valid drops next cycle.
- Glitch: key 0 high for 5 cycles, then low → no event; keys_stable stays 0.
- Keys 1 and 3 pressed simultaneously → events appear in order key 1, then key 3, on consecutive cycles with ready held high.
- evt_ready = 0, then 6 distinct edges → first 4 queued in order, last 2 dropped. overflow = 1 and stays 1 after draining. Heads hold steady while stalled.
- FIFO full, and a write coincides with evt_ready = 1 → the new event is kept and overflow stays 0.
- Reset asserted with 3 queued events and key 0 held → evt_valid = 0 and overflow = 0 next cycle. After release, a press event for key 0 appears 11 edges later.
